display_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
- Shares one hex-to-seven-segment decoder (4-bit address in, active-low 7-bit segments out) across all digits.
- Each cycle it drives the decoder address and the matching active-low digit enable.
- Holds a double-buffered digit value register, so host updates take effect only at frame boundaries (no tearing).

---
 rtl/display_scan_if.sv | 27 ++
 rtl/display_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// Host-side bundle for the seven-segment scan controller.
// The master drives the scan enable and digit values; the slave (the
// controller) returns the decoder address, anode enables and status flags.
interface display_scan_if #(
   parameter int NDIGITS = 4
);
   localparam int IW = $clog2(NDIGITS);

   logic                   enable;
   logic [4*NDIGITS-1:0]   values;
   logic                   load;
   logic [3:0]             address;
   logic [NDIGITS-1:0]     anode;
   logic [IW-1:0]          digit_idx;
   logic                   frame_done;
   logic                   upd_pending;

   modport master (
      output enable, values, load,
      input  address, anode, digit_idx, frame_done, upd_pending
   );

   modport slave (
      input  enable, values, load,
      output address, anode, digit_idx, frame_done, upd_pending
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode seven-segment
// display. One shared decoder address and one active-low anode per cycle;
// each digit slot starts with a dark blanking window to prevent ghosting.
// Host values are double buffered and applied only at frame boundaries
// (or immediately while idle), so a frame never mixes old and new data.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module display_scan_ctrl #(
   parameter int NDIGITS  = 4,
   parameter int PRESCALE = 1000,
   parameter int BLANK    = 16
) (
   input logic          clock,
   input logic          reset,
   display_scan_if.slave bus
);

   localparam int IW = $clog2(NDIGITS);
   localparam int CW = $clog2(PRESCALE);
   localparam int VW = 4 * NDIGITS;

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

   state_t             state, state_nx;
   logic [CW-1:0]      cnt, cnt_nx;
   logic [IW-1:0]      idx, idx_nx;
   logic [VW-1:0]      shadow, shadow_nx;
   logic [VW-1:0]      active, active_nx;
   logic               pending, pending_nx;
   logic               apply;
   logic               digit_on;
   logic [3:0]         address_q, address_nx;
   logic [NDIGITS-1:0] anode_q, anode_nx;
   logic               frame_done_q, frame_done_nx;

   // FSM state register: scan state, prescale count and digit index.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         idx   <= idx_nx;
      end
   end

   // Next-state logic: slot counting, digit advance and blank/show phase.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the block can leave a value unassigned and infer a latch.
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      if (!bus.enable) begin
         state_nx = S_IDLE;
         cnt_nx   = '0;
         idx_nx   = '0;
      end else begin
         if (state == S_IDLE) begin
            cnt_nx = '0;
            idx_nx = '0;
         end else if (cnt == CW'(PRESCALE - 1)) begin
            cnt_nx = '0;
            idx_nx = (idx == IW'(NDIGITS - 1)) ? '0 : idx + IW'(1);
         end else begin
            cnt_nx = cnt + CW'(1);
         end
         // The phase follows the count, so a zero-length blank goes straight to SHOW.
         state_nx = ((BLANK != 0) && (cnt_nx < CW'(BLANK))) ? S_BLANK : S_SHOW;
      end
   end

   // Double buffer: shadow captures host loads, active swaps at frame end or while idle.
   always_comb begin
      apply      = pending && (frame_done_q || (state == S_IDLE));
      active_nx  = apply ? shadow : active;
      shadow_nx  = bus.load ? bus.values : shadow;
      pending_nx = bus.load || (pending && !apply);
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [NDIGITS-1:0] lz_mask;

   // Mark digits above the most significant non-zero nibble; digit 0 is never masked.
   always_comb begin : lz_scan
      logic all_zero;
      all_zero = 1'b1;
      lz_mask  = '0;
      for (int k = NDIGITS - 1; k > 0; k--) begin
         all_zero   = all_zero && (active_nx[4*k +: 4] == 4'h0);
         lz_mask[k] = all_zero;
      end
   end

   assign digit_on = ~lz_mask[idx_nx];
`else
   assign digit_on = 1'b1;
`endif

   // Output decode: values for the registered outputs, derived from the next state.
   always_comb begin
      address_nx    = active_nx[4*idx_nx +: 4];
      anode_nx      = '1;
      frame_done_nx = 1'b0;
      if ((state_nx == S_SHOW) && digit_on) begin
         anode_nx[idx_nx] = 1'b0;
      end
      if ((state_nx != S_IDLE) && (idx_nx == IW'(NDIGITS - 1)) &&
          (cnt_nx == CW'(PRESCALE - 1))) begin
         frame_done_nx = 1'b1;
      end
   end

   // Value buffer registers.
   always_ff @(posedge clock) begin
      // NOTE: the value buffers are reset along with everything else so a
      // restart never shows stale digits; there are no memories to exempt.
      if (reset) begin
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
      end else begin
         shadow  <= shadow_nx;
         active  <= active_nx;
         pending <= pending_nx;
      end
   end

   // Output registers: glitch-free anode and address drive.
   always_ff @(posedge clock) begin
      if (reset) begin
         address_q    <= 4'h0;
         anode_q      <= '1;
         frame_done_q <= 1'b0;
      end else begin
         address_q    <= address_nx;
         anode_q      <= anode_nx;
         frame_done_q <= frame_done_nx;
      end
   end

   assign bus.address     = address_q;
   assign bus.anode       = anode_q;
   assign bus.digit_idx   = idx;
   assign bus.frame_done  = frame_done_q;
   assign bus.upd_pending = pending;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with NDIGITS=4, PRESCALE=8, BLANK=2.
// The stimulus process pushes cycle-tagged expectations; the monitor compares
// them against the DUT outputs on the falling edge of the matching cycle.
module tb_display_scan_ctrl;

   localparam int NDIG = 4;
   localparam int PRE  = 8;
   localparam int BLK  = 2;

   // Packed compare word: {pend, frame_done, digit_idx[1:0], anode[3:0], address[3:0]}
   localparam logic [11:0] M_ALL    = 12'hFFF;
   localparam logic [11:0] M_NOPEND = 12'h7FF;
   localparam logic [11:0] M_IDLE   = 12'h7F0;
   localparam logic [11:0] M_PEND   = 12'h800;
   localparam logic [11:0] RST_VAL  = {1'b0, 1'b0, 2'd0, 4'hF, 4'h0};
   localparam logic [11:0] IDLE_VAL = {1'b0, 1'b0, 2'd0, 4'hF, 4'h0};

   typedef struct {
      int          cyc;
      string       name;
      logic [11:0] val;
      logic [11:0] mask;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   display_scan_if #(.NDIGITS(NDIG)) bus();

   display_scan_ctrl #(.NDIGITS(NDIG), .PRESCALE(PRE), .BLANK(BLK)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(string name, logic [11:0] got, logic [11:0] exp, logic [11:0] mask);
      checks++;
      if ((got & mask) !== (exp & mask)) begin
         failures++;
         $display("FAIL %s @cyc %0d: got pend/fd/idx/anode/addr=%03h expected %03h (mask %03h)",
                  name, cyc, got & mask, exp & mask, mask);
      end
   endtask

   task automatic expect_at(int c, string name, logic [11:0] val, logic [11:0] mask);
      exp_t e;
      e.cyc  = c;
      e.name = name;
      e.val  = val;
      e.mask = mask;
      sb.push_back(e);
   endtask

   // Expected outputs for slot s, cycle c of a frame showing word v.
   function automatic logic [11:0] exp_word(logic [15:0] v, int s, int c, logic pend);
      logic [3:0] an;
      logic       shown;
      logic       fd;
      an    = 4'hF;
      shown = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      shown = (s == 0);
      for (int k = s; k < NDIG; k++) if (v[4*k +: 4] != 4'h0) shown = 1'b1;
`endif
      if ((c >= BLK) && shown) an[s] = 1'b0;
      fd = (s == NDIG - 1) && (c == PRE - 1);
      return {pend, fd, 2'(s), an, v[4*s +: 4]};
   endfunction

   task automatic push_frame(int base, logic [15:0] v, logic pend, logic [11:0] mask,
                             int ncyc, string tag);
      for (int i = 0; i < ncyc; i++) begin
         expect_at(base + i, $sformatf("%s s%0d c%0d", tag, i / PRE, i % PRE),
                   exp_word(v, i / PRE, i % PRE, pend), mask);
      end
   endtask

   task automatic expect_pend(int c, logic p, string tag);
      expect_at(c, tag, {p, 11'h000}, M_PEND);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_until(int c);
      while (cyc < c) tick();
   endtask

   // Monitor: compare every expectation tagged with the current cycle.
   always @(negedge clock) begin : monitor
      exp_t keep[$];
      keep = {};
      foreach (sb[i]) begin
         if (sb[i].cyc == cyc) begin
            check(sb[i].name,
                  {bus.upd_pending, bus.frame_done, bus.digit_idx, bus.anode, bus.address},
                  sb[i].val, sb[i].mask);
         end else if (sb[i].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL %s: expectation for cycle %0d not compared (now %0d)",
                     sb[i].name, sb[i].cyc, cyc);
         end else begin
            keep.push_back(sb[i]);
         end
      end
      sb = keep;
   end

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int t, f3, f4, f5, f6, f7, f8, f9;

      reset      = 1'b1;
      bus.enable = 1'b0;
      bus.load   = 1'b0;
      bus.values = 16'h0000;
      repeat (3) tick();

      // Reset state.
      t = cyc;
      expect_at(t, "reset state", RST_VAL, M_ALL);

      // Release reset, enable and load 1234 together: frame 1 still shows the
      // reset data, the load takes effect at the first frame boundary.
      reset      = 1'b0;
      bus.enable = 1'b1;
      bus.load   = 1'b1;
      bus.values = 16'h1234;
      push_frame(t + 1,  16'h0000, 1'b1, M_ALL, 32, "f1");
      push_frame(t + 33, 16'h1234, 1'b0, M_ALL, 32, "f2");
      tick();
      bus.load = 1'b0;

      // Load ABCD mid-slot 1: current frame keeps 1234, next frame shows ABCD.
      f3 = t + 65;
      f4 = f3 + 32;
      push_frame(f3, 16'h1234, 1'b0, M_NOPEND, 32, "f3");
      expect_pend(f3 + 10, 1'b0, "f3 pend before load");
      expect_pend(f3 + 11, 1'b1, "f3 pend after load");
      expect_pend(f3 + 31, 1'b1, "f3 pend at frame_done");
      push_frame(f4, 16'hABCD, 1'b0, M_NOPEND, 32, "f4");
      expect_pend(f4, 1'b0, "f4 pend cleared");
      wait_until(f3 + 10);
      bus.load   = 1'b1;
      bus.values = 16'hABCD;
      tick();
      bus.load = 1'b0;

      // Two loads in a row (last wins), then a load in the frame_done cycle:
      // 9E0F is applied at that boundary, 5678 one frame later.
      f5 = f4 + 32;
      f6 = f5 + 32;
      expect_pend(f4 + 2,  1'b0, "f4 pend before load");
      expect_pend(f4 + 3,  1'b1, "f4 pend after load");
      expect_pend(f4 + 31, 1'b1, "f4 pend at frame_done");
      push_frame(f5, 16'h9E0F, 1'b1, M_ALL, 32, "f5");
      wait_until(f4 + 2);
      bus.load   = 1'b1;
      bus.values = 16'h1111;
      tick();
      bus.values = 16'h9E0F;
      tick();
      bus.load = 1'b0;
      wait_until(f4 + 31);
      bus.load   = 1'b1;
      bus.values = 16'h5678;
      tick();
      bus.load = 1'b0;

      // Drop enable during SHOW of slot 2, load while idle, then re-enable.
      push_frame(f6, 16'h5678, 1'b0, M_ALL, 19, "f6");
      expect_at(f6 + 19, "idle c0", IDLE_VAL, M_IDLE);
      expect_at(f6 + 20, "idle c1", IDLE_VAL, M_IDLE);
      expect_at(f6 + 21, "idle c2", IDLE_VAL, M_IDLE);
      expect_pend(f6 + 19, 1'b0, "idle pend before load");
      expect_pend(f6 + 20, 1'b1, "idle pend after load");
      expect_pend(f6 + 21, 1'b0, "idle pend applied");
      wait_until(f6 + 18);
      bus.enable = 1'b0;
      tick();
      bus.load   = 1'b1;
      bus.values = 16'h4321;
      tick();
      bus.load = 1'b0;
      tick();
      bus.enable = 1'b1;

      // Restart at slot 0 with the idle-applied data, then reset mid-frame.
      f7 = f6 + 22;
      f8 = f7 + 14;
      push_frame(f7, 16'h4321, 1'b0, M_NOPEND, 13, "f7");
      expect_pend(f7 + 4, 1'b0, "f7 pend before load");
      expect_pend(f7 + 5, 1'b1, "f7 pend after load");
      expect_at(f7 + 13, "mid-frame reset", RST_VAL, M_ALL);
      push_frame(f8, 16'h0000, 1'b0, M_NOPEND, 32, "f8");
      wait_until(f7 + 4);
      bus.load   = 1'b1;
      bus.values = 16'h7777;
      tick();
      bus.load = 1'b0;
      wait_until(f7 + 12);
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // Value with leading zeros: 0050.
      f9 = f8 + 32;
      expect_pend(f8 + 5,  1'b0, "f8 pend before load");
      expect_pend(f8 + 6,  1'b1, "f8 pend after load");
      expect_pend(f8 + 31, 1'b1, "f8 pend at frame_done");
      push_frame(f9, 16'h0050, 1'b0, M_ALL, 32, "f9");
      wait_until(f8 + 5);
      bus.load   = 1'b1;
      bus.values = 16'h0050;
      tick();
      bus.load = 1'b0;

      wait_until(f9 + 33);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
